// File: rtl/rll27_decoder_if.sv
// Serial RLL(2,7) decoder bus.
// Code-bit strobe in, decoded word and error status out.
interface rll27_decoder_if;
  logic       en_i;
  logic       code_i;
  logic [3:0] data_o;
  logic [2:0] len_o;
  logic       valid_o;
  logic       err_o;
  logic [7:0] err_cnt_o;

  modport master (
    output en_i, code_i,
    input  data_o, len_o, valid_o,
    input  err_o, err_cnt_o
  );

  modport slave (
    input  en_i, code_i,
    output data_o, len_o, valid_o,
    output err_o, err_cnt_o
  );
endinterface

// File: rtl/rll27_decoder.sv
// Serial RLL(2,7) decoder: parses 4/6/8-bit codewords
// into 2/3/4-bit data words, flags and counts illegal code.
module rll27_decoder (
  input  logic          clk_i,
  input  logic          arst_i,
  rll27_decoder_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  state_t     r_state;
  // Oldest 7 bits; the live code bit completes the 8-bit window.
  logic [6:0] r_sr;
  logic [3:0] r_cnt;
  logic [3:0] r_data;
  logic [2:0] r_len;
  logic       r_valid;
  logic       r_err;
  logic [7:0] r_ecnt;

  logic [7:0] w_pat;
  logic [3:0] w_n;
  logic       w_hit;
  logic       w_pre;
  logic [3:0] w_data;
  logic [2:0] w_len;

  assign w_pat = {r_sr, bus.code_i};
  assign w_n   = r_cnt + 4'd1;

  // Classify the w_n newest bits: full codeword, live prefix, or neither.
  always_comb begin
    w_hit  = 1'b0;
    w_pre  = 1'b0;
    w_data = 4'd0;
    w_len  = 3'd0;
    case (w_n)
      4'd1: w_pre = 1'b1;
      4'd2: w_pre = (w_pat[1:0] != 2'b11);
      4'd3: w_pre = w_pat[2:0] inside
              {3'b010, 3'b100, 3'b000, 3'b001};
      4'd4: begin
        case (w_pat[3:0])
          4'b0100: begin
            w_hit  = 1'b1;
            w_data = 4'b0010;
            w_len  = 3'd2;
          end
          4'b1000: begin
            w_hit  = 1'b1;
            w_data = 4'b0011;
            w_len  = 3'd2;
          end
          4'b1001, 4'b0001,
          4'b0010, 4'b0000: w_pre = 1'b1;
          default: ;
        endcase
      end
      4'd5: w_pre = w_pat[4:0] inside
              {5'b10010, 5'b00010, 5'b00100, 5'b00001};
      4'd6: begin
        case (w_pat[5:0])
          6'b000100: begin
            w_hit  = 1'b1;
            w_data = 4'b0000;
            w_len  = 3'd3;
          end
          6'b100100: begin
            w_hit  = 1'b1;
            w_data = 4'b0010;
            w_len  = 3'd3;
          end
          6'b001000: begin
            w_hit  = 1'b1;
            w_data = 4'b0011;
            w_len  = 3'd3;
          end
          6'b001001, 6'b000010: w_pre = 1'b1;
          default: ;
        endcase
      end
      4'd7: w_pre = w_pat[6:0] inside
              {7'b0010010, 7'b0000100};
      4'd8: begin
        case (w_pat)
          8'b00100100: begin
            w_hit  = 1'b1;
            w_data = 4'b0010;
            w_len  = 3'd4;
          end
          8'b00001000: begin
            w_hit  = 1'b1;
            w_data = 4'b0011;
            w_len  = 3'd4;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Parser FSM with registered word, strobes and error count.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ecnt  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (bus.en_i) begin
        r_sr <= w_pat[6:0];
        unique case (r_state)
          S_IDLE: begin
            r_cnt   <= 4'd1;
            r_state <= S_COLLECT;
          end
          S_COLLECT: begin
            if (w_hit) begin
              r_data  <= w_data;
              r_len   <= w_len;
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else if (w_pre) begin
              r_cnt <= w_n;
            end else begin
              r_err   <= 1'b1;
              if (r_ecnt != 8'hFF)
                r_ecnt <= r_ecnt + 8'd1;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.data_o    = r_data;
  assign bus.len_o     = r_len;
  assign bus.valid_o   = r_valid;
  assign bus.err_o     = r_err;
  assign bus.err_cnt_o = r_ecnt;

endmodule

// File: tb/tb_rll27_decoder.sv
// Testbench for rll27_decoder: directed steps plus
// random codeword streams against a table-driven model.
module tb_rll27_decoder;

  logic clk_i;
  logic arst_i;

  rll27_decoder_if bus ();

  rll27_decoder dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vec;
  int miss;

  int cw     [7];
  int cw_len [7];
  int cw_dat [7];
  int cw_dl  [7];

  int m_n;
  int m_acc;
  int e_valid;
  int e_err;
  int e_data;
  int e_len;
  int e_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, {31'd0, bus.valid_o}, e_valid);
    chk({tag, ".err"},   {31'd0, bus.err_o},   e_err);
    chk({tag, ".ecnt"},  {24'd0, bus.err_cnt_o}, e_cnt);
    chk({tag, ".data"},  {28'd0, bus.data_o},  e_data);
    chk({tag, ".len"},   {29'd0, bus.len_o},   e_len);
  endtask

  task automatic model_reset();
    m_n = 0;
    m_acc = 0;
    e_valid = 0;
    e_err = 0;
    e_data = 0;
    e_len = 0;
    e_cnt = 0;
  endtask

  // Reference: accumulate bits, then look them up in the codeword table.
  task automatic model_bit(input logic b);
    int mask;
    bit hit;
    bit pre;
    e_valid = 0;
    e_err = 0;
    m_acc = ((m_acc << 1) | int'(b)) & 8'hFF;
    m_n++;
    mask = (1 << m_n) - 1;
    hit = 0;
    pre = 0;
    for (int i = 0; i < 7; i++) begin
      if (cw_len[i] == m_n && (m_acc & mask) == cw[i]) begin
        hit = 1;
        e_data = cw_dat[i];
        e_len = cw_dl[i];
      end
      if (cw_len[i] > m_n &&
          (cw[i] >> (cw_len[i] - m_n)) == (m_acc & mask))
        pre = 1;
    end
    if (hit) begin
      e_valid = 1;
      m_n = 0;
      m_acc = 0;
    end else if (!pre) begin
      e_err = 1;
      if (e_cnt < 255) e_cnt++;
      m_n = 0;
      m_acc = 0;
    end
  endtask

  task automatic send(input logic e, input logic b,
                      input string tag);
    bus.en_i = e;
    bus.code_i = b;
    @(posedge clk_i);
    #1;
    if (e) model_bit(b);
    else begin
      e_valid = 0;
      e_err = 0;
    end
    chk_all(tag);
    bus.en_i = 1'b0;
  endtask

  task automatic send_cw(input int idx, input int gap,
                         input string tag);
    for (int k = cw_len[idx] - 1; k >= 0; k--) begin
      send(1'b1, 1'(cw[idx] >> k), tag);
      for (int g = 0; g < gap; g++)
        send(1'b0, 1'($urandom), tag);
    end
  endtask

  initial begin
    cw[0] = 'b0100;     cw_len[0] = 4; cw_dat[0] = 'b10;   cw_dl[0] = 2;
    cw[1] = 'b1000;     cw_len[1] = 4; cw_dat[1] = 'b11;   cw_dl[1] = 2;
    cw[2] = 'b000100;   cw_len[2] = 6; cw_dat[2] = 'b000;  cw_dl[2] = 3;
    cw[3] = 'b100100;   cw_len[3] = 6; cw_dat[3] = 'b010;  cw_dl[3] = 3;
    cw[4] = 'b001000;   cw_len[4] = 6; cw_dat[4] = 'b011;  cw_dl[4] = 3;
    cw[5] = 'b00100100; cw_len[5] = 8; cw_dat[5] = 'b0010; cw_dl[5] = 4;
    cw[6] = 'b00001000; cw_len[6] = 8; cw_dat[6] = 'b0011; cw_dl[6] = 4;

    vec = 0;
    miss = 0;
    model_reset();
    arst_i = 1'b0;
    bus.en_i = 1'b0;
    bus.code_i = 1'b0;
    #12;
    chk_all("reset");
    @(negedge clk_i);
    arst_i = 1'b1;

    // Single 2-bit word.
    send_cw(0, 0, "cw0100");
    chk("t1.data", {28'd0, bus.data_o}, 32'h2);
    chk("t1.len", {29'd0, bus.len_o}, 32'd2);

    // Two 8-bit words back to back.
    send_cw(6, 0, "cw8a");
    chk("t2.data", {28'd0, bus.data_o}, 32'h3);
    send_cw(5, 0, "cw8b");
    chk("t2.len", {29'd0, bus.len_o}, 32'd4);

    // Enable toggling every cycle.
    send_cw(1, 1, "gap1");
    send_cw(3, 1, "gap3");
    send_cw(4, 1, "gap4");
    send_cw(2, 1, "gap2");
    chk("t3.data", {28'd0, bus.data_o}, 32'h0);
    chk("t3.len", {29'd0, bus.len_o}, 32'd3);

    // Illegal 11 then recovery.
    send(1'b1, 1'b1, "err11a");
    send(1'b1, 1'b1, "err11b");
    chk("t4.ecnt", {24'd0, bus.err_cnt_o}, 32'd1);
    send_cw(0, 0, "after_err");

    // Reset in the middle of 001000.
    send(1'b1, 1'b0, "pre_rst");
    send(1'b1, 1'b0, "pre_rst");
    send(1'b1, 1'b1, "pre_rst");
    #2;
    arst_i = 1'b0;
    #1;
    model_reset();
    chk_all("mid_rst");
    @(posedge clk_i);
    #1;
    chk_all("mid_rst_hold");
    @(negedge clk_i);
    arst_i = 1'b1;
    send_cw(1, 0, "post_rst");
    chk("t5.data", {28'd0, bus.data_o}, 32'h3);

    // Error counter saturation.
    for (int p = 0; p < 300; p++) begin
      send(1'b1, 1'b1, "sat_a");
      send(1'b1, 1'b1, "sat_b");
    end
    chk("t6.sat", {24'd0, bus.err_cnt_o}, 32'd255);

    // Random mix of codewords, stray bits and enable gaps.
    for (int r = 0; r < 250; r++) begin
      if ($urandom_range(7) == 0)
        send(1'b1, 1'($urandom), "rnd_bit");
      else
        send_cw(int'($urandom_range(6)),
                int'($urandom_range(2) == 0 ?
                     $urandom_range(2) : 0),
                "rnd_cw");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
